// File: rtl/pcie4_msix_pkg.sv
// Shared types and constants for the MSI-X interrupt requester.
package pcie4_msix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        vmask;
  } tbl_entry_t;

  // Entries come out of reset masked so nothing fires before the host programs them.
  localparam tbl_entry_t TBL_RESET = '{addr: 64'd0, data: 32'd0, vmask: 1'b1};

  // Fields of the hard-block interface this requester never uses.
  localparam logic [1:0] VEC_PENDING_TIE = 2'b00;
  localparam logic [2:0] ATTR_TIE        = 3'b000;
  localparam logic       TPH_PRESENT_TIE = 1'b0;
  localparam logic [1:0] TPH_TYPE_TIE    = 2'b00;
  localparam logic [7:0] TPH_ST_TAG_TIE  = 8'h00;

endpackage

// File: rtl/pcie4_msix_irq_requester_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, searching upward with wrap.
module msix_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Rotating priority search starting at ptr.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie4_msix_irq_requester.sv
// MSI-X interrupt requester: turns per-vector user requests into single
// MSI-X transactions on the hard block, one at a time, with retry/backoff.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no transaction; pick the next eligible pending vector
//   ISSUE   | one-cycle msix_int_vector pulse with held address/data
//   WAIT    | waiting for sent/fail; timeout counts as fail
//   BACKOFF | fixed pause after a fail before re-issuing the same vector
module pcie4_msix_irq_requester
  import pcie4_msix_pkg::*;
#(
  parameter int C_NUM_VECTORS     = 8,
  parameter int C_FUNCTION_NUMBER = 0,
  parameter int C_MAX_RETRY       = 3,
  parameter int C_BACKOFF_CYCLES  = 16,
  parameter int C_TIMEOUT_CYCLES  = 1024,
  localparam int IW = $clog2(C_NUM_VECTORS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [C_NUM_VECTORS-1:0] irq_req,
  input  logic                     tbl_wr_en,
  input  logic [IW-1:0]            tbl_wr_idx,
  input  logic [63:0]              tbl_wr_addr,
  input  logic [31:0]              tbl_wr_data,
  input  logic                     tbl_wr_vmask,
  input  logic [3:0]               msix_enable,
  input  logic [3:0]               msix_mask,
  output logic [63:0]              msix_address,
  output logic [31:0]              msix_data,
  output logic                     msix_int_vector,
  input  logic                     msix_sent,
  input  logic                     msix_fail,
  output logic [7:0]               msix_function_number,
  output logic [1:0]               msix_vec_pending,
  output logic [2:0]               msix_attr,
  output logic                     msix_tph_present,
  output logic [1:0]               msix_tph_type,
  output logic [7:0]               msix_tph_st_tag,
  output logic [C_NUM_VECTORS-1:0] pending,
  output logic                     err_drop,
  output logic [IW-1:0]            err_vec
);

  localparam int TMAX = (C_TIMEOUT_CYCLES > C_BACKOFF_CYCLES) ? C_TIMEOUT_CYCLES : C_BACKOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(C_MAX_RETRY + 2);

  state_t                   state, state_n;
  tbl_entry_t               tbl [C_NUM_VECTORS];
  logic [C_NUM_VECTORS-1:0] irq_q, rise, vmask_v, elig, pending_n;
  logic [C_NUM_VECTORS-1:0] arb_grant, grant_oh;
  logic [IW-1:0]            arb_idx, grant_idx, ptr;
  logic                     arb_valid, fn_ok;
  logic [TW-1:0]            tmr, tmr_n;
  logic [RW-1:0]            retry, retry_n, retry_inc;
  logic                     take, clr, drop;
  logic                     cfg_unused;

  assign msix_function_number = 8'(C_FUNCTION_NUMBER);
  assign msix_vec_pending     = VEC_PENDING_TIE;
  assign msix_attr            = ATTR_TIE;
  assign msix_tph_present     = TPH_PRESENT_TIE;
  assign msix_tph_type        = TPH_TYPE_TIE;
  assign msix_tph_st_tag      = TPH_ST_TAG_TIE;
  assign msix_int_vector      = (state == ISSUE);
  assign cfg_unused           = ^{msix_enable, msix_mask};

  assign fn_ok     = msix_enable[C_FUNCTION_NUMBER] & ~msix_mask[C_FUNCTION_NUMBER];
  assign rise      = irq_req & ~irq_q;
  assign elig      = pending & ~vmask_v & {C_NUM_VECTORS{fn_ok}};
  assign retry_inc = retry + 1'b1;
  // A fresh edge on the completing vector re-arms it, so set beats clear.
  assign pending_n = (pending & ~(clr ? grant_oh : '0)) | rise;

  // Gather per-vector mask bits from the table.
  always_comb begin
    vmask_v = '0;
    for (int i = 0; i < C_NUM_VECTORS; i++) vmask_v[i] = tbl[i].vmask;
  end

  msix_rr_arbiter #(.N(C_NUM_VECTORS), .IW(IW)) u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Vector table; written by the register block, visible the following cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < C_NUM_VECTORS; i++) tbl[i] <= TBL_RESET;
    end else if (tbl_wr_en && (int'(tbl_wr_idx) < C_NUM_VECTORS)) begin
      tbl[tbl_wr_idx] <= '{addr: tbl_wr_addr, data: tbl_wr_data, vmask: tbl_wr_vmask};
    end
  end

  // Next-state, timer and retry decisions.
  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    retry_n = retry;
    take    = 1'b0;
    clr     = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          take    = 1'b1;
          retry_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // Timer hits zero in WAIT cycle C_TIMEOUT_CYCLES-1.
        tmr_n   = TW'(C_TIMEOUT_CYCLES - 2);
        state_n = WAIT;
      end
      WAIT: begin
        if (msix_sent) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else if (msix_fail || (tmr == '0)) begin
          retry_n = retry_inc;
          if (retry_inc > RW'(C_MAX_RETRY)) begin
            clr     = 1'b1;
            drop    = 1'b1;
            state_n = IDLE;
          end else begin
            tmr_n   = TW'(C_BACKOFF_CYCLES - 1);
            state_n = BACKOFF;
          end
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      BACKOFF: begin
        if (tmr == '0) state_n = (|(elig & grant_oh)) ? ISSUE : IDLE;
        else           tmr_n   = tmr - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pending bitmap, held transaction and error reporting.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      tmr          <= '0;
      retry        <= '0;
      irq_q        <= '0;
      pending      <= '0;
      ptr          <= '0;
      grant_idx    <= '0;
      grant_oh     <= '0;
      msix_address <= '0;
      msix_data    <= '0;
      err_drop     <= 1'b0;
      err_vec      <= '0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      retry    <= retry_n;
      irq_q    <= irq_req;
      pending  <= pending_n;
      err_drop <= drop;
      if (drop) err_vec <= grant_idx;
      if (take) begin
        grant_idx    <= arb_idx;
        grant_oh     <= arb_grant;
        msix_address <= tbl[arb_idx].addr;
        msix_data    <= tbl[arb_idx].data;
        ptr          <= (arb_idx == IW'(C_NUM_VECTORS - 1)) ? '0 : arb_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/pcie4_msix_irq_requester.md
Name: pcie4_msix_irq_requester

Overview:
Upstream neighbour of the MSI-X config wirethrough. It converts per-vector user interrupt requests into single-interrupt MSI-X transactions, driving the S_PCIE4_CFG_MSIX side of the PCIe4 hard block. Vector address/data come from a small local table written by the host-facing register block. The requester issues one interrupt at a time, round-robin across vectors, and waits for sent or fail. On fail it retries with a fixed backoff, up to a bounded limit.

Parameters:
C_NUM_VECTORS, 8, number of user interrupt vectors (2..32)
C_FUNCTION_NUMBER, 0, PCIe function these interrupts belong to (0..3)
C_MAX_RETRY, 3, fail retries before a vector is dropped
C_BACKOFF_CYCLES, 16, idle cycles between a fail and the retry
C_TIMEOUT_CYCLES, 1024, cycles waited for sent/fail before abort

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
irq_req  in  C_NUM_VECTORS  level interrupt requests; a rising edge sets pending
tbl_wr_en  in  1  table write strobe
tbl_wr_idx  in  clog2(C_NUM_VECTORS)  table entry index
tbl_wr_addr  in  64  message address for the entry
tbl_wr_data  in  32  message data for the entry
tbl_wr_vmask  in  1  per-vector mask bit for the entry
msix_enable  in  4  cfg enable per PF
msix_mask  in  4  cfg function mask per PF
msix_address  out  64  to s_address
msix_data  out  32  to s_data
msix_int_vector  out  1  to s_int_vector, 1-cycle pulse
msix_sent  in  1  from s_sent
msix_fail  in  1  from s_fail
msix_function_number  out  8  constant C_FUNCTION_NUMBER
msix_vec_pending  out  2  tied 0
msix_attr  out  3  tied 0
msix_tph_present  out  1  tied 0
msix_tph_type  out  2  tied 0
msix_tph_st_tag  out  8  tied 0
pending  out  C_NUM_VECTORS  pending bitmap, for status readback
err_drop  out  1  1-cycle pulse when a vector is dropped
err_vec  out  clog2(C_NUM_VECTORS)  vector index for err_drop

Behaviour:
- Reset, asynchronous: the FSM is IDLE, pending=0, the table is all zero with every vmask=1, msix_address/data=0, msix_int_vector=0, err_drop=0, err_vec=0, and the round-robin pointer is 0.
- Edge detect: irq_req is registered. A rising edge sets pending[i]. A bit already set stays set; requests coalesce.
- Eligibility: the vector is not masked, msix_enable[C_FUNCTION_NUMBER]=1, and msix_mask[C_FUNCTION_NUMBER]=0.
- Arbiter: round-robin over pending & eligible, starting at ptr. After a grant, ptr becomes grant+1, wrapping modulo C_NUM_VECTORS.
- IDLE: if any vector is eligible, latch grant/addr/data and go to ISSUE. The decision is registered, so ISSUE follows 1 cycle after eligibility.
- ISSUE: msix_int_vector=1 for exactly one cycle, with address and data stable. Go to WAIT and clear the timeout counter.
- WAIT: address and data stay held.
  - sent: clear pending[grant] and return to IDLE. A new edge on that vector in the same cycle wins, and pending stays 1.
  - fail: increment retry. If retry > C_MAX_RETRY, clear pending, pulse err_drop, and go to IDLE. Otherwise go to BACKOFF.
  - Timeout reaching C_TIMEOUT_CYCLES-1: treated as fail.
  - sent and fail in the same cycle: sent wins.
- BACKOFF: count C_BACKOFF_CYCLES, then go to ISSUE with the same vector. If the vector has become ineligible, go to IDLE and keep it pending. Retry resets on each new grant.
- Table writes take effect the next cycle. A write to the in-flight vector does not alter the held address/data until the next grant.
- Disable mid-flight (msix_enable falls during WAIT): finish the WAIT normally. No new issue occurs while disabled.
- areset asserted mid-transaction: everything is immediately at reset values. The in-flight interrupt is lost.
- Max throughput: one interrupt per 3 cycles plus hard-block latency.

Decomposition:
- Shared package pcie4_msix_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, BACKOFF)
  - the table entry typedef {addr[63:0], data[31:0], vmask}
  - the tied-off TPH/attr constants
- One sub-module, msix_rr_arbiter: a parameterised round-robin arbiter that takes a request vector and a pointer and produces a one-hot/index grant plus a valid flag.

Test Plan:
- Single vector: entry 2 = {addr 0xFEE0_0000_0000_1000, data 0x42}, vmask=0, enable=1. Raise irq_req[2] and hold msix_sent low until it is driven. Expect:
  - a 1-cycle msix_int_vector pulse with those values
  - after sent 3 cycles later, pending[2]=0.
- Round-robin: vectors 0, 3 and 5 rise in the same cycle and sent returns 2 cycles after each issue. Issue order is 0, 3, 5. Raising 0 again then issues 0 after 5.
- Retry: 3 consecutive fails on vector 1. Expect 4 issues spaced by 16 idle backoff cycles, then sent, and no err_drop. With 4 fails, expect err_drop=1, err_vec=1, pending[1]=0.
- Masking: msix_mask[0]=1 with vector 4 pending gives no issue. Clearing the mask produces an issue 1 cycle later. With vmask=1 on the vector, pending stays 1 and nothing issues.
- Timeout: no response after an issue. Expect a re-issue at cycle 1024+16 after the first pulse.
- Reset: assert areset during WAIT. Outputs go to 0 and pending to 0 asynchronously. After release, the FSM is IDLE and no spurious pulse appears.
